// File: rtl/tlul_pkg.sv
// TL-UL channel structures: host-to-device (A channel plus d_ready) and
// device-to-host (D channel plus a_ready).
package tlul_pkg;
  localparam logic [2:0] TL_PUT_FULL = 3'h0;
  localparam logic [2:0] TL_GET      = 3'h4;
  localparam logic [2:0] TL_ACK      = 3'h0;
  localparam logic [2:0] TL_ACK_DATA = 3'h1;

  typedef struct packed {
    logic                       a_valid;
    logic [2:0]                 a_opcode;
    logic [2:0]                 a_param;
    logic [top_pkg::TL_SZW-1:0] a_size;
    logic [top_pkg::TL_AIW-1:0] a_source;
    logic [top_pkg::TL_AW-1:0]  a_address;
    logic [top_pkg::TL_DBW-1:0] a_mask;
    logic [top_pkg::TL_DW-1:0]  a_data;
    logic                       d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic                       d_valid;
    logic [2:0]                 d_opcode;
    logic [2:0]                 d_param;
    logic [top_pkg::TL_SZW-1:0] d_size;
    logic [top_pkg::TL_AIW-1:0] d_source;
    logic [top_pkg::TL_DIW-1:0] d_sink;
    logic [top_pkg::TL_DW-1:0]  d_data;
    logic                       d_error;
    logic                       a_ready;
  } tl_d2h_t;
endpackage

// File: rtl/top_pkg.sv
// Bus-wide TL-UL width constants shared by every TL-UL block in the system.
package top_pkg;
  localparam int TL_AW  = 32;          // address width
  localparam int TL_DW  = 32;          // data width
  localparam int TL_AIW = 8;           // a_source / d_source width
  localparam int TL_DIW = 1;           // d_sink width
  localparam int TL_SZW = 2;           // size field width
  localparam int TL_DBW = TL_DW / 8;   // byte-mask width
endpackage

// File: rtl/tlul_host_arb2.sv
// Two-host to one-device TL-UL arbiter with zero-latency pass-through.
// Each forwarded request has a_source[TAG_BIT] replaced by the host index;
// responses are steered back by that same bit, so the device side may
// return responses out of order. Per-host outstanding counters throttle
// each host at MAX_OUTSTANDING in-flight requests.
//
// Ports:
//   clk_i, rst_ni     clock, asynchronous active-low reset
//   tl_h0_i/tl_h0_o   host 0 (data port) request / response
//   tl_h1_i/tl_h1_o   host 1 (instruction port) request / response
//   tl_d_o/tl_d_i     shared device request / response
//   busy_o            high while any request is outstanding
module tlul_host_arb2
  import tlul_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter bit          FIXED_PRIO      = 1'b0,
  parameter int unsigned TAG_BIT         = top_pkg::TL_AIW - 1
) (
  input  logic    clk_i,
  input  logic    rst_ni,
  input  tl_h2d_t tl_h0_i,
  output tl_d2h_t tl_h0_o,
  input  tl_h2d_t tl_h1_i,
  output tl_d2h_t tl_h1_o,
  output tl_h2d_t tl_d_o,
  input  tl_d2h_t tl_d_i,
  output logic    busy_o
);
  localparam int unsigned   CW      = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTSTANDING);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_e;

  state_e        lock_q, lock_d;
  logic          grant_q, grant_d;
  logic          last_q, last_d;
  logic [CW-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

  logic    elig0, elig1, sel, sel_valid, a_hs;
  logic    d_host, d_ready_sel, d_hs;
  logic    inc0, inc1, dec0, dec1;
  tl_h2d_t sel_req;
  tl_d2h_t d_rsp;

  // Increment and decrement together cancel; a decrement at zero saturates.
  function automatic logic [CW-1:0] cnt_next(input logic [CW-1:0] c,
                                             input logic inc, input logic dec);
    if (inc && !dec) return c + CW'(1);
    if (dec && !inc && (c != '0)) return c - CW'(1);
    return c;
  endfunction

  assign elig0 = tl_h0_i.a_valid && (cnt0_q < CNT_MAX);
  assign elig1 = tl_h1_i.a_valid && (cnt1_q < CNT_MAX);

  // While locked the granted host is forwarded on its raw a_valid so a stalled
  // request stays put; if that host drops a_valid the lock is released.
  always_comb begin : arbitrate
    sel       = 1'b0;
    sel_valid = 1'b0;
    if (lock_q == LOCKED) begin
      sel       = grant_q;
      sel_valid = grant_q ? tl_h1_i.a_valid : tl_h0_i.a_valid;
    end else begin
      sel_valid = elig0 | elig1;
      if (FIXED_PRIO)            sel = !elig0 && elig1;
      else if (elig0 && elig1)   sel = !last_q;
      else                       sel = elig1;
    end
  end

  assign a_hs        = sel_valid && tl_d_i.a_ready;
  assign d_host      = tl_d_i.d_source[TAG_BIT];
  assign d_ready_sel = d_host ? tl_h1_i.d_ready : tl_h0_i.d_ready;
  assign d_hs        = tl_d_i.d_valid && d_ready_sel;

  assign inc0 = a_hs && !sel;
  assign inc1 = a_hs &&  sel;
  assign dec0 = d_hs && !d_host;
  assign dec1 = d_hs &&  d_host;

  always_comb begin : a_mux
    sel_req                   = sel ? tl_h1_i : tl_h0_i;
    sel_req.a_valid           = sel_valid;
    sel_req.a_source[TAG_BIT] = sel;
    sel_req.d_ready           = d_ready_sel;
  end

  assign tl_d_o = sel_req;

  always_comb begin : d_route
    d_rsp                   = tl_d_i;
    d_rsp.d_source[TAG_BIT] = 1'b0;
    d_rsp.d_valid           = 1'b0;
    d_rsp.a_ready           = 1'b0;
    tl_h0_o                 = d_rsp;
    tl_h1_o                 = d_rsp;
    tl_h0_o.d_valid         = tl_d_i.d_valid && !d_host;
    tl_h1_o.d_valid         = tl_d_i.d_valid &&  d_host;
    tl_h0_o.a_ready         = tl_d_i.a_ready && sel_valid && !sel;
    tl_h1_o.a_ready         = tl_d_i.a_ready && sel_valid &&  sel;
  end

  always_comb begin : next_state
    lock_d  = lock_q;
    grant_d = grant_q;
    last_d  = last_q;
    case (lock_q)
      IDLE: begin
        if (sel_valid && !tl_d_i.a_ready) begin
          lock_d  = LOCKED;
          grant_d = sel;
        end
      end
      LOCKED: begin
        if (!sel_valid || tl_d_i.a_ready) lock_d = IDLE;
      end
      default: lock_d = IDLE;
    endcase
    if (a_hs) last_d = sel;
    cnt0_d = cnt_next(cnt0_q, inc0, dec0);
    cnt1_d = cnt_next(cnt1_q, inc1, dec1);
  end

  // State registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q  <= IDLE;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
    end else begin
      lock_q  <= lock_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
    end
  end

  assign busy_o = (cnt0_q != '0) || (cnt1_q != '0);

  h0_tag_clear: assert property (@(posedge clk_i) disable iff (!rst_ni)
    tl_h0_i.a_valid |-> !tl_h0_i.a_source[TAG_BIT]);
  h1_tag_clear: assert property (@(posedge clk_i) disable iff (!rst_ni)
    tl_h1_i.a_valid |-> !tl_h1_i.a_source[TAG_BIT]);
  d0_legal: assert property (@(posedge clk_i) disable iff (!rst_ni)
    dec0 |-> ((cnt0_q != '0) || inc0));
  d1_legal: assert property (@(posedge clk_i) disable iff (!rst_ni)
    dec1 |-> ((cnt1_q != '0) || inc1));

endmodule

// File: doc/tlul_host_arb2.md
Name: tlul_host_arb2

Overview:
- Two-host to one-device TL-UL arbiter. It lets the instruction and data ports of the CPU share a single TL-UL bus segment, for example a single-port memory path or an area-reduced system bus.
- It sits downstream of the per-port FIFOs or randomizers and tags each request's a_source with the host index. Responses are routed back by tag, so out-of-order responses from downstream randomizers are handled correctly.
- Zero-latency pass-through: no storage in the A or D channel.

Parameters:
- MAX_OUTSTANDING, 4: maximum in-flight requests per host, range 1..15. A host is blocked while its count equals this value.
- FIXED_PRIO, 1'b0: 0 selects round-robin; 1 gives host 0 absolute priority.
- TAG_BIT, top_pkg::TL_AIW-1: the a_source/d_source bit that carries the host index.

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  reset; asynchronous assert, active-low
- tl_h0_i  input  tl_h2d_t  host 0 request (data port, by convention)
- tl_h0_o  output  tl_d2h_t  host 0 response
- tl_h1_i  input  tl_h2d_t  host 1 request (instruction port)
- tl_h1_o  output  tl_d2h_t  host 1 response
- tl_d_o  output  tl_h2d_t  shared device request
- tl_d_i  input  tl_d2h_t  shared device response
- busy_o  output  1  high when either outstanding counter is nonzero

Behaviour:
- Registered state:
  - grant_q, 1b: the host currently owning the A channel.
  - lock_q, 1b.
  - last_q, 1b: the last host that completed an A handshake.
  - cnt0_q, cnt1_q, each clog2(MAX_OUTSTANDING+1) bits.
- Reset values: grant_q=0, lock_q=0, last_q=1 (so host 0 wins first), cnt*_q=0.
- Outputs are combinational from state and inputs. With idle inputs, tl_d_o.a_valid=0, tl_h*_o.d_valid=0, tl_h*_o.a_ready=0, busy_o=0.
- Eligibility: host n is eligible when tl_hn_i.a_valid=1 and cntn_q<MAX_OUTSTANDING.
- Arbitration, state IDLE (lock_q=0):
  - Round-robin mode: if both hosts are eligible, pick !last_q. If one is eligible, pick it.
  - FIXED_PRIO=1: host 0 is picked whenever it is eligible.
  - The selected host drives tl_d_o the same cycle, with a_source[TAG_BIT] replaced by the host index.
- Transition to LOCKED: in IDLE, if tl_d_o.a_valid=1 and tl_d_i.a_ready=0, set grant_q=selected and lock_q=1.
- LOCKED state (lock_q=1):
  - Only grant_q is forwarded, regardless of the other host. This keeps A-channel fields stable, as TL-UL requires.
  - Exit to IDLE on a handshake (tl_d_o.a_valid & tl_d_i.a_ready).
- A handshake:
  - tl_hn_o.a_ready = tl_d_i.a_ready when host n is selected, else 0.
  - On a handshake, last_q is set to the granted host and that host's counter increments.
- D routing:
  - h = tl_d_i.d_source[TAG_BIT].
  - tl_hh_o carries the D fields with d_source[TAG_BIT] forced to 0, and d_valid=tl_d_i.d_valid.
  - The other host sees d_valid=0.
  - tl_d_o.d_ready = tl_hh_i.d_ready.
  - A D handshake decrements cnth_q.
- Counter increment and decrement for the same host in the same cycle: no net change.
- A D handshake tagged for a host whose counter is 0 is an illegal response. The count saturates at 0 and a simulation assertion fires.
- Host a_source[TAG_BIT] must be 0. A nonzero value is overwritten, and a simulation assertion fires.
- A host that deasserts a_valid while unaccepted violates protocol. The arbiter still exits LOCKED once a_valid from grant_q drops, and the next cycle is IDLE.
- Reset asserted mid-transaction: all state clears immediately and in-flight responses are not tracked. The system resets the device side together with the arbiter.
- No combinational path from tl_h*_i.a_valid to tl_h*_o.a_ready other than the select mux; the only ready path is a_ready from the device. Loops through the D channel are forbidden.

Test Plan:
- Single host 0 Get to address 0x100 with a_source=3 → tl_d_o.a_source=0x03 and a_valid in the same cycle. Response d_source=0x03 goes to h0 only; h1 d_valid stays 0. cnt0 goes 0→1→0.
- Both hosts valid every cycle, a_ready=1, round-robin mode → grants alternate 0,1,0,1. The first grant after reset is host 0. Host 1 requests carry a_source with TAG_BIT set.
- Device a_ready=0 for 3 cycles while host 1 is granted and host 0 asserts valid → tl_d_o stays host 1's request unchanged for all 3 cycles. Host 0 is granted in the cycle after acceptance.
- Host 0 issues 4 requests with no responses (MAX_OUTSTANDING=4) → 5th request a_ready=0 and host 1 is still served. After one D response to host 0, a new host 0 request is accepted the next cycle.
- Out-of-order responses: host 1 tag first, then host 0, with the h1 d_ready=0 for 2 cycles → tl_d_o.d_ready=0 for those cycles, no response reaches h0, and each counter decrements only on its own handshake.
- FIXED_PRIO=1 with host 0 continuously eligible → host 1 is never granted. With host 0's counter saturated at 4, host 1 is granted. Async reset mid-lock clears lock_q, counters and busy_o=0 without waiting for a clock edge.
